// File: rtl/timer_apb_responder.sv
// timer_apb_responder: APB register file and 64-bit counter core for the system timer.
// Holds control/compare/interrupt/halt registers and drives the level interrupt tim_int.
module timer_apb_responder #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [63:0] CMP_RST     = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tim_psel,
    input  logic        tim_penable,
    input  logic        tim_pwrite,
    input  logic [11:0] tim_paddr,
    input  logic [31:0] tim_pwdata,
    input  logic [3:0]  tim_pstrb,
    output logic [31:0] tim_prdata,
    output logic        tim_pready,
    output logic        tim_pslverr,
    input  logic        dbg_mode,
    output logic        tim_int
);
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic [31:0] prdata_q, prdata_d;
    logic        slverr_q, slverr_d;
    logic        en_q, en_d, int_en_q, int_en_d, int_st_q, int_st_d;
    logic        halt_req_q, halt_req_d, halt_ack_q, int_q;
    logic [63:0] cnt_q, cnt_d, cmp_q, cmp_d;
    logic        addr_err, commit, inc, carry;
    logic [2:0]  idx;
    logic [7:0]  we;
    logic [31:0] wmask, rdata;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    assign idx      = tim_paddr[4:2];
    assign addr_err = (|tim_paddr[1:0]) || (|tim_paddr[11:5]);
    assign commit   = state_q == ACCESS && tim_pwrite && !addr_err;
    assign we       = commit ? 8'(1) << idx : 8'd0;
    assign wmask    = {{8{tim_pstrb[3]}}, {8{tim_pstrb[2]}}, {8{tim_pstrb[1]}}, {8{tim_pstrb[0]}}};
    assign inc      = en_q && !halt_ack_q;
    assign carry    = inc && (&cnt_q[31:0]);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE:    state_d = (tim_psel && !tim_penable) ? SETUP : IDLE;
            SETUP: begin
                wait_d = 2'd0;
                if (!tim_psel)
                    state_d = IDLE;
                else if (tim_penable)
                    state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
            end
            WAIT: begin
                if (!tim_psel)
                    state_d = IDLE;
                else if (wait_q == 2'(WAIT_STATES - 1))
                    state_d = ACCESS;
                else
                    wait_d = wait_q + 2'd1;
            end
            ACCESS:  state_d = tim_psel ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        case (idx)
            3'd0: rdata = {31'd0, en_q};
            3'd1: rdata = cnt_q[31:0];
            3'd2: rdata = cnt_q[63:32];
            3'd3: rdata = cmp_q[31:0];
            3'd4: rdata = cmp_q[63:32];
            3'd5: rdata = {31'd0, int_en_q};
            3'd6: rdata = {31'd0, int_st_q};
            3'd7: rdata = {30'd0, halt_ack_q, halt_req_q};
            default: rdata = 32'd0;
        endcase
    end

    // Read data and error are captured on the edge that enters ACCESS and zeroed otherwise.
    assign prdata_d = (state_d == ACCESS && !tim_pwrite && !addr_err) ? rdata : 32'd0;
    assign slverr_d = state_d == ACCESS && addr_err;

    // A write to one counter half replaces it; the other half still takes the carry.
    assign cnt_d[31:0]  = we[1] ? merge(cnt_q[31:0], tim_pwdata, wmask) : cnt_q[31:0] + {31'd0, inc};
    assign cnt_d[63:32] = we[2] ? merge(cnt_q[63:32], tim_pwdata, wmask) : cnt_q[63:32] + {31'd0, carry};
    assign cmp_d[31:0]  = we[3] ? merge(cmp_q[31:0], tim_pwdata, wmask) : cmp_q[31:0];
    assign cmp_d[63:32] = we[4] ? merge(cmp_q[63:32], tim_pwdata, wmask) : cmp_q[63:32];
    assign en_d         = (we[0] && tim_pstrb[0]) ? tim_pwdata[0] : en_q;
    assign int_en_d     = (we[5] && tim_pstrb[0]) ? tim_pwdata[0] : int_en_q;
    assign halt_req_d   = (we[7] && tim_pstrb[0]) ? tim_pwdata[0] : halt_req_q;
    assign int_st_d     = (cnt_q == cmp_q) || (int_st_q && !(we[6] && tim_pstrb[0] && tim_pwdata[0]));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            wait_q     <= 2'd0;
            prdata_q   <= 32'd0;
            slverr_q   <= 1'b0;
            en_q       <= 1'b0;
            int_en_q   <= 1'b0;
            int_st_q   <= 1'b0;
            halt_req_q <= 1'b0;
            halt_ack_q <= 1'b0;
            int_q      <= 1'b0;
            cnt_q      <= 64'd0;
            cmp_q      <= CMP_RST;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            prdata_q   <= prdata_d;
            slverr_q   <= slverr_d;
            en_q       <= en_d;
            int_en_q   <= int_en_d;
            int_st_q   <= int_st_d;
            halt_req_q <= halt_req_d;
            halt_ack_q <= halt_req_q && dbg_mode;
            int_q      <= int_st_q && int_en_q;
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
        end
    end

    assign tim_prdata  = prdata_q;
    assign tim_pready  = state_q == ACCESS;
    assign tim_pslverr = slverr_q;
    assign tim_int     = int_q;
endmodule

// File: tb/tb_timer_apb_responder.sv
// tb_timer_apb_responder: directed APB bench for the timer responder with a result queue
// and a timestamp model of the counter (value as a function of clock edge index).
module tb_timer_apb_responder;
    logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic        tim_psel = 1'b0, tim_penable = 1'b0, tim_pwrite = 1'b0, dbg_mode = 1'b0;
    logic [11:0] tim_paddr = 12'd0;
    logic [31:0] tim_pwdata = 32'd0;
    logic [3:0]  tim_pstrb = 4'hF;
    logic [31:0] tim_prdata;
    logic        tim_pready, tim_pslverr, tim_int;

    typedef struct {
        string       tag;
        logic        chk;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, last_commit = 0;
    logic [63:0] m_val = 64'd0;
    int          m_edge = 0;
    logic        m_run = 1'b0;

    timer_apb_responder dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tim_psel(tim_psel), .tim_penable(tim_penable),
        .tim_pwrite(tim_pwrite), .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr),
        .dbg_mode(dbg_mode), .tim_int(tim_int)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    // Counter value seen just before clock edge e.
    function automatic logic [63:0] cnt_at(input int e);
        return m_run ? m_val + 64'(e - m_edge - 1) : m_val;
    endfunction

    task automatic model_stop(input int s);
        m_val  = cnt_at(s) + 64'd1;
        m_edge = s;
        m_run  = 1'b0;
    endtask

    task automatic model_start(input int s);
        m_edge = s;
        m_run  = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // src: 0 = exp_d as given, 1 = model counter low half, 2 = model counter high half
    task automatic apb(input string tag, input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int src, input logic [31:0] exp_d, input logic exp_e);
        exp_t        e;
        int          n;
        logic [63:0] cv;
        @(negedge sys_clk);
        cv = cnt_at(cyc + 3);
        sb.push_back('{tag: tag, chk: !wr, err: exp_e,
                       data: (src == 1) ? cv[31:0] : (src == 2) ? cv[63:32] : exp_d});
        tim_psel = 1'b1; tim_penable = 1'b0; tim_pwrite = wr;
        tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
        @(negedge sys_clk);
        tim_penable = 1'b1;
        n = 1;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!tim_pready && n < 12);
        check({tag, "_lat"}, 64'(n), 64'd3);
        e = sb.pop_front();
        check({e.tag, "_err"}, tim_pslverr, e.err);
        if (e.chk) check({e.tag, "_data"}, tim_prdata, e.data);
        last_commit = cyc + 1;
        @(negedge sys_clk);
        tim_psel = 1'b0; tim_penable = 1'b0; tim_pwrite = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d);
        apb(tag, 1'b1, a, d, 4'hF, 0, 32'd0, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        apb(tag, 1'b0, a, 32'd0, 4'hF, 0, exp, 1'b0);
    endtask

    task automatic rdc(input string tag, input int half);
        apb(tag, 1'b0, (half == 1) ? 12'h004 : 12'h008, 32'd0, 4'hF, half, 32'd0, 1'b0);
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge sys_clk);
    endtask

    initial begin
        idle(3);
        check("rst_pready", tim_pready, 0);
        check("rst_pslverr", tim_pslverr, 0);
        check("rst_prdata", tim_prdata, 0);
        check("rst_int", tim_int, 0);
        sys_rst_n = 1'b1;
        rd("r_tcr", 12'h000, 32'h0);
        rdc("r_tdr0", 1);
        rdc("r_tdr1", 2);
        rd("r_tcmp0", 12'h00C, 32'hFFFF_FFFF);
        rd("r_tcmp1", 12'h010, 32'hFFFF_FFFF);
        rd("r_tier", 12'h014, 32'h0);
        rd("r_tisr", 12'h018, 32'h0);
        rd("r_thcsr", 12'h01C, 32'h0);

        wr("c_tdr0", 12'h004, 32'hFFFF_FF00); m_val[31:0] = 32'hFFFF_FF00;
        wr("c_tdr1", 12'h008, 32'h0);         m_val[63:32] = 32'h0;
        wr("c_tcr", 12'h000, 32'h1);          model_start(last_commit);
        idle(254);
        rdc("c_lo", 1);
        rdc("c_hi", 2);

        wr("i_tcr0", 12'h000, 32'h0);  model_stop(last_commit);
        wr("i_tdr0", 12'h004, 32'h0);  m_val[31:0] = 32'h0;
        wr("i_tdr1", 12'h008, 32'h0);  m_val[63:32] = 32'h0;
        wr("i_cmp0", 12'h00C, 32'hF);
        wr("i_cmp1", 12'h010, 32'h0);
        wr("i_tier", 12'h014, 32'h1);
        wr("i_tcr1", 12'h000, 32'h1);  model_start(last_commit);
        idle(16);
        check("i_int_early", tim_int, 0);
        idle(1);
        check("i_int_rise", tim_int, 1);
        rdc("i_cnt_runs", 1);
        rd("i_tisr_held", 12'h018, 32'h1);
        check("i_int_held", tim_int, 1);
        wr("i_w1c", 12'h018, 32'h1);
        idle(1);
        check("i_int_clr", tim_int, 0);
        rd("i_tisr_clr", 12'h018, 32'h0);

        wr("h_tcr0", 12'h000, 32'h0);  model_stop(last_commit);
        rdc("h_stop_a", 1);
        idle(254);
        rdc("h_stop_b", 1);
        rdc("h_stop_hi", 2);
        dbg_mode = 1'b1;
        wr("h_tcr1", 12'h000, 32'h1);  model_start(last_commit);
        wr("h_req", 12'h01C, 32'h1);   model_stop(last_commit + 1);
        rd("h_ack", 12'h01C, 32'h3);
        rdc("h_frz_a", 1);
        idle(50);
        rdc("h_frz_b", 1);
        dbg_mode = 1'b0;               model_start(cyc + 1);
        idle(20);
        rdc("h_resume", 1);
        rd("h_ack_clr", 12'h01C, 32'h1);

        wr("w_tcr0", 12'h000, 32'h0);  model_stop(last_commit);
        wr("w_tdr0", 12'h004, 32'hFFFF_FF00); m_val[31:0] = 32'hFFFF_FF00;
        wr("w_tdr1", 12'h008, 32'hFFFF_FFFF); m_val[63:32] = 32'hFFFF_FFFF;
        wr("w_tcr1", 12'h000, 32'h1);  model_start(last_commit);
        idle(254);
        rdc("w_lo", 1);
        rdc("w_hi", 2);

        apb("e_wr20", 1'b1, 12'h020, 32'h0, 4'hF, 0, 32'h0, 1'b1);
        apb("e_rd06", 1'b0, 12'h006, 32'h0, 4'hF, 0, 32'h0, 1'b1);
        rd("e_tcr_kept", 12'h000, 32'h1);
        apb("e_strb", 1'b1, 12'h00C, 32'hAABB_CC55, 4'b0001, 0, 32'h0, 1'b0);
        rd("e_cmp0", 12'h00C, 32'h0000_0055);
        rd("e_cmp1", 12'h010, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
